// File: rtl/fu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// fu_issue_arbiter
//
// Shares one integer functional unit among NUM_RS reservation stations.
// Each cycle one ready station is picked round-robin and granted (one-hot,
// combinational) so it can retire that entry on the same clock edge. The
// granted operation is executed here: ALU ops complete in one cycle, a
// multiply occupies the unit for MUL_LAT cycles. Results leave on a single
// registered forwarding bus {valid, rob tag, value}.
//
// Parameters:
//   NUM_RS   number of requesting reservation stations (2..8)
//   MUL_LAT  multiply latency, grant to forward-bus valid (>= 2)
//
// Ports:
//   clk       clock, all state updates on posedge
//   rst_n     asynchronous active-low reset
//   flush     synchronous pipeline flush; drops in-flight and same-cycle work
//   rs_valid  [NUM_RS]     bit i: station i presents a ready op
//   rs_op     [NUM_RS*42]  slice i: [41:38] opcode, [37:32] tag,
//                          [31:16] valA, [15:0] valB
//   rs_grant  [NUM_RS]     one-hot combinational grant
//   fwd_out   [23]         registered {valid, tag[5:0], result[15:0]}
//   fu_busy               registered; high while a multiply holds the unit
//
// Optional feature (macro ARB_PERF_CNT_EN):
//   perf_grants [32]  cycles with a grant, saturating
//   perf_stalls [32]  cycles with a request but no grant, saturating
//   Both reset by rst_n and held during flush.
// -----------------------------------------------------------------------------
module fu_issue_arbiter #(
  parameter int NUM_RS  = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NUM_RS-1:0]    rs_valid,
  input  logic [NUM_RS*42-1:0] rs_op,
  output logic [NUM_RS-1:0]    rs_grant,
  output logic [22:0]          fwd_out,
  output logic                 fu_busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_grants,
  output logic [31:0]          perf_stalls
`endif
);

  localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int CNT_W = $clog2(MUL_LAT + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [22:0]        fwd_q, fwd_d;

  // Multiply operand/tag latches (datapath, only read while in ST_MUL)
  logic [5:0]         mul_tag_q, mul_tag_d;
  logic [15:0]        mul_a_q, mul_a_d;
  logic [15:0]        mul_b_q, mul_b_d;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------------
  logic               grant_vld;
  logic [PTR_W-1:0]   grant_idx;

  always_comb begin
    int idx;
    // NOTE: every signal driven here gets a default before any conditional
    // logic, so no path leaves it unassigned and no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    // The unit only accepts work when idle, not flushing and out of reset.
    if (rst_n && (state_q == ST_IDLE) && !flush) begin
      for (int k = 0; k < NUM_RS; k++) begin
        idx = (int'(rr_ptr_q) + k) % NUM_RS;
        if (!grant_vld && rs_valid[idx]) begin
          grant_vld = 1'b1;
          grant_idx = PTR_W'(idx);
        end
      end
    end
  end

  always_comb begin
    rs_grant = '0;
    if (grant_vld) rs_grant = NUM_RS'(1) << grant_idx;
  end

  // ---------------------------------------------------------------------------
  // Selected operation and single-cycle ALU
  // ---------------------------------------------------------------------------
  logic [41:0] sel_op;
  logic [3:0]  sel_opc;
  logic [5:0]  sel_tag;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic [15:0] alu_res;
  logic [15:0] mul_prod;

  assign sel_op  = rs_op[grant_idx*42 +: 42];
  assign sel_opc = sel_op[41:38];
  assign sel_tag = sel_op[37:32];
  assign sel_a   = sel_op[31:16];
  assign sel_b   = sel_op[15:0];

  always_comb begin
    alu_res = sel_a;
    case (sel_opc)
      OP_ADD:  alu_res = sel_a + sel_b;
      OP_SUB:  alu_res = sel_a - sel_b;
      OP_AND:  alu_res = sel_a & sel_b;
      OP_OR:   alu_res = sel_a | sel_b;
      OP_XOR:  alu_res = sel_a ^ sel_b;
      OP_SHL:  alu_res = sel_a << sel_b[3:0];
      OP_SHR:  alu_res = sel_a >> sel_b[3:0];
      default: alu_res = sel_a;  // opcode 8..15 pass valA; mul handled apart
    endcase
  end

  // 16-bit context keeps only the low half of the product.
  assign mul_prod = mul_a_q * mul_b_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    int nxt_ptr;
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    fwd_d     = {1'b0, fwd_q[21:0]};  // valid is a single-cycle pulse
    mul_tag_d = mul_tag_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    nxt_ptr   = (int'(grant_idx) + 1) % NUM_RS;

    if (flush) begin
      // Drop whatever is in flight; the round-robin pointer is kept. No grant
      // is issued this cycle, so no same-cycle result can be produced.
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            rr_ptr_d = PTR_W'(nxt_ptr);
            if (sel_opc == OP_MUL) begin
              state_d   = ST_MUL;
              cnt_d     = CNT_W'(MUL_LAT - 1);
              busy_d    = 1'b1;
              mul_tag_d = sel_tag;
              mul_a_d   = sel_a;
              mul_b_d   = sel_b;
            end else begin
              fwd_d = {1'b1, sel_tag, alu_res};
            end
          end
        end
        ST_MUL: begin
          // Counter reaching 1 is the last in-flight cycle: the product is
          // registered now, so it is visible exactly MUL_LAT cycles after the
          // grant, together with fu_busy dropping and a new grant possible.
          if (cnt_q == CNT_W'(1)) begin
            fwd_d   = {1'b1, mul_tag_q, mul_prod};
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      fwd_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      fwd_q    <= fwd_d;
    end
  end

  // NOTE: the multiply operand latches are pure datapath and carry no reset;
  // they are always written before ST_MUL can read them.
  always_ff @(posedge clk) begin
    mul_tag_q <= mul_tag_d;
    mul_a_q   <= mul_a_d;
    mul_b_q   <= mul_b_d;
  end

  assign fwd_out = fwd_q;
  assign fu_busy = busy_q;

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_grants_q;
  logic [31:0] perf_stalls_q;
  logic        stall_cycle;

  // A cycle with requests but no grant (busy with a multiply). Flush cycles
  // hold both counters and are therefore excluded.
  assign stall_cycle = (|rs_valid) && !grant_vld && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grants_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (grant_vld && (perf_grants_q != '1)) perf_grants_q <= perf_grants_q + 32'd1;
      if (stall_cycle && (perf_stalls_q != '1)) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_grants = perf_grants_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: doc/fu_issue_arbiter.md
Name: fu_issue_arbiter

Overview:
Shares one integer functional unit (FU) among NUM_RS reservation stations. Each cycle it picks one ready operation round-robin and returns a one-hot grant so the selected station retires that entry. It executes the operation (single-cycle ALU ops, multi-cycle multiply) and drives the result onto one forwarding bus in the valid/tag/value format the stations snoop.

Parameters:
NUM_RS, 4, number of requesting reservation stations (2..8)
MUL_LAT, 3, multiply latency in cycles from grant to forward-bus valid (>=2)

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush (mispredict); highest priority after reset
rs_valid  input  NUM_RS  bit i: station i presents a ready op (both operands resolved)
rs_op  input  NUM_RS*42  slice i = [42*i+41:42*i]; per slice [41:38] opcode, [37:32] rob tag, [31:16] valA, [15:0] valB
rs_grant  output  NUM_RS  one-hot combinational grant; station i removes its op on the same posedge
fwd_out  output  23  [22] valid, [21:16] rob tag, [15:0] result; registered
fu_busy  output  1  registered; high while a multiply occupies the FU

Behaviour:
- Reset (rst_n=0, async): state=IDLE, rr_ptr=0, fwd_out=0, fu_busy=0, latency counter=0. rs_grant=0 while rst_n=0.
- States: IDLE (can accept) and MUL (multiply in flight).
- Arbitration: in IDLE with flush=0, grant the first i with rs_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_RS. rs_grant=0 in MUL, during flush, or when no rs_valid bit is set. After a grant to i, rr_ptr <= (i+1) mod NUM_RS. rr_ptr does not change without a grant.
- Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl by valB[3:0], 6 logical shr by valB[3:0], 7 mul (low 16 bits of product), 8-15 pass valA.
- All arithmetic is 16-bit wrap-around; carries are discarded.
- Single-cycle op granted in cycle t: fwd_out={1,tag,result} in cycle t+1 for exactly one cycle. State stays IDLE, so back-to-back grants are allowed every cycle.
- Mul granted in cycle t: latch tag/operands, state->MUL, counter<=MUL_LAT-1, fu_busy=1 from t+1.
  - While in MUL, decrement the counter each cycle.
  - In the cycle the counter==1, register the product and return to IDLE.
  - fwd_out is valid in cycle t+MUL_LAT and fu_busy is 0 in that same cycle. The next grant is possible in cycle t+MUL_LAT.
- fwd_out[22] is 0 in every cycle not named above. fwd_out[21:0] may hold stale data when valid=0.
- Flush: in-flight multiply is dropped and no forward-bus pulse is emitted for it. A single-cycle result whose grant occurred in the flush cycle is also not produced. Next cycle: state=IDLE, fu_busy=0, fwd_out[22]=0. rr_ptr is preserved.
- Reset mid-multiply: everything clears immediately and no result appears.
- rs_valid/rs_op are sampled only in the grant cycle. Changes to a non-granted station's op have no effect.

Optional Feature:
ARB_PERF_CNT_EN:
- Defined: adds outputs perf_grants (32) and perf_stalls (32), both reset to 0 by rst_n and held by flush.
  - perf_grants increments on every cycle with a grant.
  - perf_stalls increments on every cycle with any rs_valid set and no grant.
  - Both saturate at all-ones.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then rs_valid=4'b0001, slice0 op=add tag 5, 0x0003+0x0004 -> rs_grant=0001 that cycle; next cycle fwd_out={1,6'd5,16'h0007}.
- rs_valid=4'b1111 held 4 cycles, all single-cycle -> grants 0001,0010,0100,1000 in order; rr_ptr back to 0; four consecutive forward pulses.
- Mul tag 9, 0x0100*0x0101, MUL_LAT=3, grant cycle t -> fu_busy=1 at t+1..t+2; rs_grant=0 at t+1..t+2 despite rs_valid=1111; fwd_out={1,9,16'h0100} at t+3; a new grant is possible at t+3.
- Sub 0x0000-0x0001 -> result 0xFFFF; shl 0x8001 by valB=0x0011 (amount 1) -> 0x0002.
- Mul granted at t, flush=1 at t+1 -> no forward pulse at t+3; fu_busy=0 at t+2; grant resumes at t+2 if a station is valid.
- rst_n low at t+1 of a multiply -> fwd_out=0 and fu_busy=0 immediately; rr_ptr=0 after release.
